uart_receiver: RTL and testbench

//  Serial 8N1 UART receive stage; the consumer of the transmitter's tx line.

---
 rtl/uart_receiver_if.sv | 25 ++
 rtl/uart_receiver.sv | 93 +++++++++
 tb/tb_uart_receiver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Receive-side bundle: serial line in, framed byte and status strobes out.
// master is the receiver, slave is whoever drives rx and consumes bytes.
interface uart_receiver_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: centre-sampled, LSB first, stop bit checked.
// A low stop bit parks the FSM in BREAK until the line returns high.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    uart_receiver_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rx_m;
    logic          rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            bus.data_out   <= 8'h00;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            cnt            <= cnt + CW'(1);
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (idx == 3'd7) state <= S_STOP;
                        else idx <= idx + 3'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            bus.data_out   <= shreg;
                            bus.data_valid <= 1'b1;
                            state          <= S_IDLE;
                        end else begin
                            bus.frame_err <= 1'b1;
                            state         <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 clocks per bit: vector table,
// hand-written corner sequences and random frames against an event model.
module tb_uart_receiver;
    localparam int CPB = 16;
    localparam int BIT_NS = 160;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_d;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    uart_receiver_if bus ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  nv = 0;
    int  ne = 0;
    int  excl_viol = 0;
    int  width_viol = 0;
    int  busy_viol = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic pend = 1'b0;
    ev_t act_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_v <= bus.data_valid;
        prev_e <= bus.frame_err;
        pend   <= bus.data_valid;
        if (pend && bus.busy) busy_viol <= busy_viol + 1;
        if (bus.data_valid && bus.frame_err) excl_viol <= excl_viol + 1;
        if ((bus.data_valid && prev_v) || (bus.frame_err && prev_e))
            width_viol <= width_viol + 1;
        if (bus.data_valid) begin
            nv <= nv + 1;
            act_q.push_back('{1'b0, bus.data_out, cyc});
        end
        if (bus.frame_err) begin
            ne <= ne + 1;
            act_q.push_back('{1'b1, bus.data_out, cyc});
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act,
                             input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        bus.rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            #(BIT_NS);
        end
        bus.rx = stop;
        #(BIT_NS);
    endtask

    task automatic wait_event(output logic ok);
        int t = 0;
        while (act_q.size() == 0 && t < 40) begin
            wait_cycles(1);
            t++;
        end
        ok = (act_q.size() != 0);
    endtask

    vec_t tbl[7];

    initial begin
        int v0, e0, st;
        logic ok;
        logic [7:0] ref_data;
        logic [7:0] d;
        logic stop;
        ev_t ev;

        tbl[0] = '{8'hAA, 1'b1, 0,  1, 0, 8'hAA};
        tbl[1] = '{8'h3C, 1'b0, 40, 0, 1, 8'hAA};
        tbl[2] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
        tbl[4] = '{8'h5A, 1'b0, 2,  0, 1, 8'hFF};
        tbl[5] = '{8'hA5, 1'b1, 0,  1, 0, 8'hA5};
        tbl[6] = '{8'h81, 1'b1, 0,  1, 0, 8'h81};

        bus.rx = 1'b1;
        rst = 1'b0;
        wait_cycles(3);
        check("rst_data", bus.data_out, 8'h00);
        check("rst_valid", bus.data_valid, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b1;
        wait_cycles(20);
        check("idle_data", bus.data_out, 8'h00);
        check("idle_busy", bus.busy, 0);
        check("idle_pulses", nv + ne, 0);

        foreach (tbl[i]) begin
            v0 = nv;
            e0 = ne;
            send_frame(tbl[i].data, tbl[i].stop);
            if (tbl[i].hold > 0) begin
                #(BIT_NS * tbl[i].hold);
                check("break_busy", bus.busy, 1);
                bus.rx = 1'b1;
            end
            wait_cycles(2 * CPB);
            check("vec_valid", nv - v0, tbl[i].exp_v);
            check("vec_ferr", ne - e0, tbl[i].exp_e);
            check("vec_data", bus.data_out, tbl[i].exp_d);
            check("vec_busy", bus.busy, 0);
        end

        act_q.delete();
        st = cyc;
        send_frame(8'h55, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(2 * CPB);
        check("b2b_count", act_q.size(), 2);
        if (act_q.size() == 2) begin
            check("b2b_d0", act_q[0].data, 8'h55);
            check("b2b_d1", act_q[1].data, 8'hFF);
            check("b2b_err", {act_q[0].err, act_q[1].err}, 0);
            check_rng("latency", act_q[0].cyc - st, 152, 158);
            check_rng("b2b_gap", act_q[1].cyc - act_q[0].cyc, 158, 162);
        end

        act_q.delete();
        bus.rx = 1'b0;
        wait_cycles(4);
        bus.rx = 1'b1;
        check("glitch_busy_hi", bus.busy, 1);
        wait_cycles(30);
        check("glitch_busy_lo", bus.busy, 0);
        check("glitch_events", act_q.size(), 0);
        check("glitch_data", bus.data_out, 8'hFF);

        v0 = nv;
        e0 = ne;
        d = 8'h7E;
        bus.rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            bus.rx = d[i];
            #(BIT_NS);
        end
        bus.rx = d[4];
        #(BIT_NS / 2);
        rst = 1'b0;
        wait_cycles(2);
        check("mid_rst_data", bus.data_out, 8'h00);
        check("mid_rst_busy", bus.busy, 0);
        bus.rx = 1'b1;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(40);
        check("abort_pulses", (nv - v0) + (ne - e0), 0);
        send_frame(8'h81, 1'b1);
        wait_cycles(CPB);
        check("after_rst_valid", nv - v0, 1);
        check("after_rst_data", bus.data_out, 8'h81);

        act_q.delete();
        ref_data = 8'h81;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            if (!stop) begin
                #(BIT_NS * $urandom_range(0, 2));
                bus.rx = 1'b1;
                #(BIT_NS);
            end else begin
                #(BIT_NS * $urandom_range(0, 2));
            end
            wait_event(ok);
            check("rnd_event", ok, 1);
            if (ok) begin
                ev = act_q.pop_front();
                check("rnd_kind", ev.err, !stop);
                if (stop) ref_data = d;
                check("rnd_ev_data", ev.data, ref_data);
            end
            check("rnd_data_out", bus.data_out, ref_data);
        end
        wait_cycles(3 * CPB);
        check("rnd_no_extra", act_q.size(), 0);
        check("rnd_busy", bus.busy, 0);

        check("excl_viol", excl_viol, 0);
        check("width_viol", width_viol, 0);
        check("busy_after_valid", busy_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
